// File: rtl/cpu_pkg.sv
// Shared CPU definitions: result/tag widths, the reserved "no tag" ROB index
// and the CDB source encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 5;

  // All-ones ROB index means "no tag"; RS and LSB use it for "operand ready".
  localparam logic [ROB_W-1:0] NO_TAG = '1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

endpackage

// File: rtl/result_fifo.sv
// Small circular result queue for one CDB producer. A push while full is
// dropped; the parent flags it. Clear beats push and pop; en low freezes all.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_in) begin
    if (en && !clear && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: queues ALU and LSB results, picks one per cycle
// round-robin and broadcasts it on a registered CDB.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [ROB_W-1:0]  alu_rob_pos,
  output logic              alu_full,
  input  logic              lsb_done,
  input  logic [DATA_W-1:0] lsb_res,
  input  logic [ROB_W-1:0]  lsb_rob_pos,
  output logic              lsb_full,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_res,
  output logic [ROB_W-1:0]  cdb_rob_pos,
  output logic              cdb_src,
  output logic              ovf_err
);

  localparam int ENT_W = DATA_W + ROB_W;

  logic             alu_empty;
  logic             lsb_empty;
  logic [ENT_W-1:0] alu_head;
  logic [ENT_W-1:0] lsb_head;
  src_e             last_grant;

  logic             grant_vld_p0;
  logic             tie_p0;
  src_e             grant_src_p0;
  logic [ENT_W-1:0] grant_ent_p0;
  logic             alu_pop_p0;
  logic             lsb_pop_p0;

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_alu_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (rdy_in),
    .clear    (clear_in),
    .push     (alu_done),
    .pop      (alu_pop_p0),
    .din      ({alu_res, alu_rob_pos}),
    .full     (alu_full),
    .empty    (alu_empty),
    .head     (alu_head)
  );

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_lsb_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (rdy_in),
    .clear    (clear_in),
    .push     (lsb_done),
    .pop      (lsb_pop_p0),
    .din      ({lsb_res, lsb_rob_pos}),
    .full     (lsb_full),
    .empty    (lsb_empty),
    .head     (lsb_head)
  );

  // ---- p0: round-robin pick among non-empty queues ----
  // A lone candidate wins outright; on a tie the source not granted by the
  // previous tie wins, so last_grant only moves when there was contention.
  always_comb begin
    grant_vld_p0 = !alu_empty || !lsb_empty;
    tie_p0       = !alu_empty && !lsb_empty;
    grant_src_p0 = SRC_ALU;
    if (tie_p0) begin
      grant_src_p0 = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
    end else if (alu_empty) begin
      grant_src_p0 = SRC_LSB;
    end
    grant_ent_p0 = (grant_src_p0 == SRC_LSB) ? lsb_head : alu_head;
    alu_pop_p0   = grant_vld_p0 && (grant_src_p0 == SRC_ALU);
    lsb_pop_p0   = grant_vld_p0 && (grant_src_p0 == SRC_LSB);
  end

  // ---- p1: registered CDB broadcast and tie history ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid   <= 1'b0;
      cdb_res     <= '0;
      cdb_rob_pos <= NO_TAG;
      cdb_src     <= 1'b0;
      last_grant  <= SRC_LSB;
    end else if (rdy_in) begin
      if (clear_in) begin
        cdb_valid <= 1'b0;
      end else if (grant_vld_p0) begin
        cdb_valid                <= 1'b1;
        {cdb_res, cdb_rob_pos}   <= grant_ent_p0;
        cdb_src                  <= 1'(grant_src_p0);
        if (tie_p0) last_grant   <= grant_src_p0;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow: a producer pushed although its full flag was up.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_err <= 1'b0;
    end else if (rdy_in && !clear_in) begin
      if ((alu_done && alu_full) || (lsb_done && lsb_full)) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based model.
module tb_cdb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [DATA_W-1:0] MARK_OVF = 32'hDEADBEEF;
  localparam logic [DATA_W-1:0] MARK_CLR = 32'hC1EA0001;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [ROB_W-1:0]  pos;
  } ent_t;

  logic              clk_in = 1'b0;
  logic              rst_n_in, rdy_in, clear_in;
  logic              alu_done, lsb_done;
  logic [DATA_W-1:0] alu_res, lsb_res;
  logic [ROB_W-1:0]  alu_rob_pos, lsb_rob_pos;
  logic              alu_full, lsb_full;
  logic              cdb_valid, cdb_src, ovf_err;
  logic [DATA_W-1:0] cdb_res;
  logic [ROB_W-1:0]  cdb_rob_pos;

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .clear_in    (clear_in),
    .alu_done    (alu_done),
    .alu_res     (alu_res),
    .alu_rob_pos (alu_rob_pos),
    .alu_full    (alu_full),
    .lsb_done    (lsb_done),
    .lsb_res     (lsb_res),
    .lsb_rob_pos (lsb_rob_pos),
    .lsb_full    (lsb_full),
    .cdb_valid   (cdb_valid),
    .cdb_res     (cdb_res),
    .cdb_rob_pos (cdb_rob_pos),
    .cdb_src     (cdb_src),
    .ovf_err     (ovf_err)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  ent_t              mq_alu[$];
  ent_t              mq_lsb[$];
  bit                m_lg;
  bit                m_vld;
  logic [DATA_W-1:0] m_res;
  logic [ROB_W-1:0]  m_pos;
  bit                m_src;
  bit                m_ovf;

  int                nchk = 0;
  int                nerr = 0;
  bit                seen_mark;
  bit                collect;
  logic [5:0]        obs_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_alu.delete();
    mq_lsb.delete();
    m_lg  = 1'b1;
    m_vld = 1'b0;
    m_res = '0;
    m_pos = '1;
    m_src = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the arbiter as described by its rules.
  task automatic model_step();
    int   na, nl;
    bit   g;
    ent_t e;
    if (rdy_in) begin
      if (clear_in) begin
        mq_alu.delete();
        mq_lsb.delete();
        m_vld = 1'b0;
      end else begin
        na = mq_alu.size();
        nl = mq_lsb.size();
        if (na > 0 && nl > 0) begin
          g    = ~m_lg;
          m_lg = g;
        end else begin
          g = (na == 0);
        end
        if (na > 0 || nl > 0) begin
          e     = g ? mq_lsb.pop_front() : mq_alu.pop_front();
          m_vld = 1'b1;
          m_res = e.res;
          m_pos = e.pos;
          m_src = g;
        end else begin
          m_vld = 1'b0;
        end
        if (alu_done) begin
          if (na == DEPTH) m_ovf = 1'b1;
          else mq_alu.push_back('{res: alu_res, pos: alu_rob_pos});
        end
        if (lsb_done) begin
          if (nl == DEPTH) m_ovf = 1'b1;
          else mq_lsb.push_back('{res: lsb_res, pos: lsb_rob_pos});
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("cdb_valid", cdb_valid, m_vld);
    chk("cdb_res", cdb_res, m_res);
    chk("cdb_rob_pos", cdb_rob_pos, m_pos);
    chk("cdb_src", cdb_src, m_src);
    chk("alu_full", alu_full, mq_alu.size() == DEPTH);
    chk("lsb_full", lsb_full, mq_lsb.size() == DEPTH);
    chk("ovf_err", ovf_err, m_ovf);
    if (cdb_valid && (cdb_res == MARK_OVF || cdb_res == MARK_CLR)) seen_mark = 1'b1;
    if (collect && cdb_valid) obs_q.push_back({cdb_src, cdb_rob_pos});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit ad, input bit ld);
    alu_done    = ad;
    alu_res     = $urandom & 32'h7FFF_FFFF;
    alu_rob_pos = ROB_W'($urandom);
    lsb_done    = ld;
    lsb_res     = $urandom & 32'h7FFF_FFFF;
    lsb_rob_pos = ROB_W'($urandom);
  endtask

  initial begin
    bit found;
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    collect  = 1'b0;
    seen_mark = 1'b0;
    drive(0, 0);
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_outputs();
    chk("reset_rob_pos", cdb_rob_pos, 5'h1F);
    rst_n_in = 1'b1;

    // Single ALU result: on the CDB one edge after it is queued
    alu_done = 1'b1; alu_res = 32'h11; alu_rob_pos = 5'd3;
    cycle();
    chk("t1_latency0", cdb_valid, 1'b0);
    drive(0, 0);
    cycle();
    chk("t1_valid", cdb_valid, 1'b1);
    chk("t1_res", cdb_res, 32'h11);
    chk("t1_pos", cdb_rob_pos, 5'd3);
    chk("t1_src", cdb_src, 1'b0);
    cycle();
    chk("t1_idle", cdb_valid, 1'b0);

    // Both producers every cycle: strict alternation starting with ALU
    collect = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1);
      alu_rob_pos = ROB_W'(i);
      lsb_rob_pos = ROB_W'(8 + i);
      cycle();
    end
    drive(0, 0);
    repeat (12) cycle();
    collect = 1'b0;
    chk("t2_count", obs_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      logic [5:0] expv;
      expv = (i % 2 == 0) ? {1'b0, 5'(i / 2)} : {1'b1, 5'(8 + i / 2)};
      if (i < obs_q.size()) chk("t2_order", obs_q[i], expv);
    end

    // Flush with a simultaneous push: queued and pushed results vanish
    for (int i = 0; i < 5; i++) begin
      drive(1, 1);
      cycle();
    end
    drive(1, 0);
    alu_res  = MARK_CLR;
    clear_in = 1'b1;
    cycle();
    clear_in = 1'b0;
    chk("t4_valid", cdb_valid, 1'b0);
    chk("t4_alu_full", alu_full, 1'b0);
    drive(0, 0);
    repeat (6) cycle();
    chk("t4_no_mark", seen_mark, 1'b0);

    // Stall with both queues loaded; clear during stall is ignored
    for (int i = 0; i < 4; i++) begin
      drive(1, 1);
      cycle();
    end
    rdy_in = 1'b0;
    cycle();
    clear_in = 1'b1;
    cycle();
    clear_in = 1'b0;
    cycle();
    rdy_in = 1'b1;
    cycle();
    drive(0, 0);
    repeat (10) cycle();

    // Overflow: fill LSB, then force a push while it is full
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        if (mq_lsb.size() == DEPTH) begin
          found = 1'b1;
        end else begin
          drive(mq_alu.size() < DEPTH, 1);
          cycle();
        end
      end
    end
    chk("t3_setup", found, 1'b1);
    chk("t3_lsb_full", lsb_full, 1'b1);
    drive(0, 1);
    lsb_res = MARK_OVF;
    cycle();
    chk("t3_ovf", ovf_err, 1'b1);
    drive(0, 0);
    repeat (12) cycle();
    chk("t3_no_mark", seen_mark, 1'b0);

    // Asynchronous reset between edges in the middle of a burst
    for (int i = 0; i < 4; i++) begin
      drive(1, 1);
      cycle();
    end
    drive(0, 0);
    #3;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("t7_valid", cdb_valid, 1'b0);
    chk("t7_ovf", ovf_err, 1'b0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (4) cycle();

    // Random traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) != 0) && (mq_alu.size() < DEPTH),
            ($urandom_range(0, 2) != 0) && (mq_lsb.size() < DEPTH));
      rdy_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rdy_in   = 1'b1;
    clear_in = 1'b0;
    drive(0, 0);
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
